if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the RV64 pipeline.
- Owns the program counter and drives `pc_addr` into the combinational instruction memory.
- Samples the returned instruction and access-fault info into the IF/ID pipeline register.
- Handles decode stalls, pipeline flushes, branch/trap redirects, and a fault-hold state, so a faulting fetch is reported exactly once and then waits for the trap redirect.

Parameters:
- RESET_VECTOR, 64'h0000_0000_0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) placed in IF/ID on reset, flush or invalid slot.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- pc_addr  out  64  current fetch PC to imem (direct copy of PC register).
- imem_instr  in  32  instruction returned by imem for pc_addr (same cycle, combinational).
- imem_exc_en  in  1  imem access fault for pc_addr.
- imem_exc_code  in  4  imem exception cause.
- imem_exc_val  in  64  imem faulting address.
- stall  in  1  decode cannot accept; hold PC and IF/ID.
- flush  in  1  kill the IF/ID contents (bubble next cycle).
- redirect_en  in  1  load new PC (taken branch/jump/trap/mret).
- redirect_pc  in  64  redirect target.
- id_pc  out  64  PC of instruction in IF/ID.
- id_instr  out  32  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.
- id_exc_en  out  1  IF/ID slot carries a fetch exception.
- id_exc_code  out  4  cause for id_exc_en.
- id_exc_val  out  64  tval for id_exc_en.

Behaviour:
- Reset (rst==0 at edge): PC=RESET_VECTOR, state=RUN, id_pc=0, id_instr=NOP_INSTR, id_valid=0, id_exc_en=0, id_exc_code=0, id_exc_val=0. Reset overrides all other inputs, including mid-stall or mid-fault.
- States:
  - RUN: normal fetch.
  - FAULT: a fault has been passed to IF/ID; fetch is frozen.
- Per-edge priority, highest first: reset > redirect_en > flush > stall > normal.
- redirect_en=1 (any state):
  - If redirect_pc[1:0]==0: PC<=redirect_pc, IF/ID<=bubble, state<=RUN.
  - If redirect_pc[1:0]!=0: PC unchanged; IF/ID loads valid=1, instr=NOP_INSTR, id_pc=redirect_pc, exc_en=1, exc_code=0 (misaligned fetch), exc_val=redirect_pc; state<=FAULT.
- flush=1 (no redirect): IF/ID<=bubble; PC and state unchanged. Flush overrides stall.
- stall=1 (no redirect/flush): PC and all IF/ID fields hold.
- Normal, state RUN, imem_exc_en=0: IF/ID<={pc_addr, imem_instr, valid=1, exc=0}; PC<=PC+4 (64-bit wrap, carry discarded).
- Normal, state RUN, imem_exc_en=1: IF/ID<={pc_addr, NOP_INSTR, valid=1, exc_en=1, imem_exc_code, imem_exc_val}; PC holds; state<=FAULT.
- Normal, state FAULT: IF/ID<=bubble; PC holds. Only redirect_en or reset leaves FAULT.
- Bubble definition: valid=0, instr=NOP_INSTR, pc=0, exc_en=0, exc_code=0, exc_val=0.
- Latency: instruction at PC appears on id_* one edge after PC is presented; throughput 1 instr/cycle with no stall.
- Invariant: id_exc_en=1 implies id_valid=1.
- imem exc_* inputs are ignored when the slot is not loaded (stall, flush, FAULT).

Test Plan:
- Reset release, RESET_VECTOR=0, imem returns 0x00500093, 0x00A00113 at PC 0 and 4 -> pc_addr 0,4,8; id_instr 0x00500093 (id_pc 0) then 0x00A00113 (id_pc 4), id_valid=1.
- stall high 2 cycles at PC=8 -> pc_addr stays 8, id_* unchanged for both cycles; resumes with PC=12 one edge after stall drops.
- redirect_en=1, redirect_pc=0x100, with stall=1 and flush=1 in the same cycle -> next cycle pc_addr=0x100, id_valid=0, id_instr=0x13; following cycle id_pc=0x100.
- imem_exc_en=1, code=1, val=0x40000 at PC 0x40000 -> id_exc_en=1, id_exc_code=1, id_exc_val=0x40000, id_pc=0x40000, exactly one cycle; then bubbles, pc_addr frozen at 0x40000 until redirect_en to 0x80 -> fetch resumes at 0x80.
- redirect_pc=0x102 -> id_exc_en=1, code=0, val=0x102, PC unchanged, state FAULT.
- rst asserted low while in FAULT with stall=1 -> next cycle pc_addr=RESET_VECTOR, id_valid=0, id_exc_en=0, state RUN.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bus: the imem port, the pipeline control inputs and the IF/ID slot outputs.
// The "slave" side is the fetch stage; the "master" side is the surrounding pipeline and imem.
interface if_stage_if;
  logic [63:0] pc_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_exc_en;
  logic [3:0]  id_exc_code;
  logic [63:0] id_exc_val;

  modport slave (
    output pc_addr,
    input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    input  stall, flush, redirect_en, redirect_pc,
    output id_pc, id_instr, id_valid, id_exc_en, id_exc_code, id_exc_val
  );

  modport master (
    input  pc_addr,
    output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    output stall, flush, redirect_en, redirect_pc,
    input  id_pc, id_instr, id_valid, id_exc_en, id_exc_code, id_exc_val
  );
endinterface

// File: rtl/if_stage.sv
// RV64 instruction-fetch stage: owns the PC, fills the IF/ID register from a combinational imem,
// and freezes in FAULT after reporting a fetch fault once, until a redirect arrives.
// Handshake: decode accepts the IF/ID slot on every edge where stall is low; while stall is high
// the slot and the PC hold. flush and redirect_en override stall.
module if_stage #(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.slave   bus,
  output logic        o_dbg_fault
);

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic        r_id_valid;
  logic        r_id_exc_en;
  logic [3:0]  r_id_exc_code;
  logic [63:0] r_id_exc_val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_VECTOR;
      r_id_pc       <= '0;
      r_id_instr    <= NOP_INSTR;
      r_id_valid    <= 1'b0;
      r_id_exc_en   <= 1'b0;
      r_id_exc_code <= '0;
      r_id_exc_val  <= '0;
    end else if (bus.redirect_en) begin
      if (bus.redirect_pc[1:0] == 2'b00) begin
        r_state       <= ST_RUN;
        r_pc          <= bus.redirect_pc;
        r_id_pc       <= '0;
        r_id_instr    <= NOP_INSTR;
        r_id_valid    <= 1'b0;
        r_id_exc_en   <= 1'b0;
        r_id_exc_code <= '0;
        r_id_exc_val  <= '0;
      end else begin
        // Misaligned target: report it as a fetch fault (cause 0) without moving the PC.
        r_state       <= ST_FAULT;
        r_id_pc       <= bus.redirect_pc;
        r_id_instr    <= NOP_INSTR;
        r_id_valid    <= 1'b1;
        r_id_exc_en   <= 1'b1;
        r_id_exc_code <= 4'd0;
        r_id_exc_val  <= bus.redirect_pc;
      end
    end else if (bus.flush || (!bus.stall && r_state == ST_FAULT)) begin
      r_id_pc       <= '0;
      r_id_instr    <= NOP_INSTR;
      r_id_valid    <= 1'b0;
      r_id_exc_en   <= 1'b0;
      r_id_exc_code <= '0;
      r_id_exc_val  <= '0;
    end else if (!bus.stall) begin
      r_id_pc    <= r_pc;
      r_id_valid <= 1'b1;
      if (bus.imem_exc_en) begin
        r_state       <= ST_FAULT;
        r_id_instr    <= NOP_INSTR;
        r_id_exc_en   <= 1'b1;
        r_id_exc_code <= bus.imem_exc_code;
        r_id_exc_val  <= bus.imem_exc_val;
      end else begin
        r_pc          <= r_pc + 64'd4;
        r_id_instr    <= bus.imem_instr;
        r_id_exc_en   <= 1'b0;
        r_id_exc_code <= '0;
        r_id_exc_val  <= '0;
      end
    end
  end

  assign bus.pc_addr     = r_pc;
  assign bus.id_pc       = r_id_pc;
  assign bus.id_instr    = r_id_instr;
  assign bus.id_valid    = r_id_valid;
  assign bus.id_exc_en   = r_id_exc_en;
  assign bus.id_exc_code = r_id_exc_code;
  assign bus.id_exc_val  = r_id_exc_val;
  assign o_dbg_fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed steps then random control traffic, every cycle compared against
// a reference model of the fetch rules.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dbg_fault;

  if_stage_if u_bus ();

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (u_bus.slave),
    .o_dbg_fault (dbg_fault)
  );

  always #5 clk = ~clk;

  // Imem content: two fixed words at 0 and 4, a scrambled pattern everywhere else.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'd0) return 32'h0050_0093;
    if (a == 64'd4) return 32'h00A0_0113;
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  logic       drv_exc;
  logic [3:0] drv_code;
  always_comb begin
    u_bus.imem_instr    = mem_word(u_bus.pc_addr);
    u_bus.imem_exc_val  = u_bus.pc_addr;
    u_bus.imem_exc_en   = drv_exc;
    u_bus.imem_exc_code = drv_code;
  end

  // Reference model: architectural view of the stage.
  typedef struct {
    logic [63:0] pc;
    logic        fault;
    logic [63:0] id_pc;
    logic [31:0] instr;
    logic        valid;
    logic        exc;
    logic [3:0]  code;
    logic [63:0] val;
  } model_t;

  model_t m;
  int n_cmp = 0;
  int n_fail = 0;

  function automatic model_t with_bubble(input model_t s);
    model_t r = s;
    r.id_pc = '0; r.instr = NOP; r.valid = 1'b0; r.exc = 1'b0; r.code = '0; r.val = '0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t s);
    model_t r = s;
    if (!rst) begin
      r.pc = '0; r.fault = 1'b0;
      r = with_bubble(r);
    end else if (u_bus.redirect_en) begin
      if (u_bus.redirect_pc % 4 == 0) begin
        r.pc = u_bus.redirect_pc; r.fault = 1'b0;
        r = with_bubble(r);
      end else begin
        r.fault = 1'b1;
        r.id_pc = u_bus.redirect_pc; r.instr = NOP; r.valid = 1'b1;
        r.exc = 1'b1; r.code = 4'd0; r.val = u_bus.redirect_pc;
      end
    end else if (u_bus.flush) begin
      r = with_bubble(r);
    end else if (u_bus.stall) begin
      r = s;
    end else if (s.fault) begin
      r = with_bubble(r);
    end else if (drv_exc) begin
      r.fault = 1'b1;
      r.id_pc = s.pc; r.instr = NOP; r.valid = 1'b1;
      r.exc = 1'b1; r.code = drv_code; r.val = s.pc;
    end else begin
      r.id_pc = s.pc; r.instr = mem_word(s.pc); r.valid = 1'b1;
      r.exc = 1'b0; r.code = '0; r.val = '0;
      r.pc = s.pc + 64'd4;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc_addr",     u_bus.pc_addr,            m.pc);
    check("id_pc",       u_bus.id_pc,              m.id_pc);
    check("id_instr",    {32'd0, u_bus.id_instr},  {32'd0, m.instr});
    check("id_valid",    {63'd0, u_bus.id_valid},  {63'd0, m.valid});
    check("id_exc_en",   {63'd0, u_bus.id_exc_en}, {63'd0, m.exc});
    check("id_exc_code", {60'd0, u_bus.id_exc_code}, {60'd0, m.code});
    check("id_exc_val",  u_bus.id_exc_val,         m.val);
    check("dbg_fault",   {63'd0, dbg_fault},       {63'd0, m.fault});
    n_cmp++;
    assert (!u_bus.id_exc_en || u_bus.id_valid) else begin
      n_fail++;
      $error("FAIL exc_implies_valid: observed exc=%0b valid=%0b expected valid=1",
             u_bus.id_exc_en, u_bus.id_valid);
    end
  endtask

  // One clock: predict from pre-edge inputs, then compare 1 time unit after the edge.
  task automatic cycle();
    model_t nx;
    nx = model_next(m);
    @(posedge clk);
    m = nx;
    #1;
    check_all();
  endtask

  task automatic set_ctl(input logic s, input logic f, input logic r, input logic [63:0] rpc);
    u_bus.stall = s; u_bus.flush = f; u_bus.redirect_en = r; u_bus.redirect_pc = rpc;
  endtask

  initial begin
    m = '{default: '0};
    m.instr = NOP;
    drv_exc = 1'b0; drv_code = 4'd0;
    set_ctl(0, 0, 0, 64'd0);

    // Reset state
    rst = 1'b0;
    cycle(); cycle();
    check("rst_pc", u_bus.pc_addr, 64'd0);
    check("rst_instr", {32'd0, u_bus.id_instr}, {32'd0, NOP});

    // Reset release, first two fetches
    rst = 1'b1;
    cycle();
    check("f0_instr", {32'd0, u_bus.id_instr}, 64'h0050_0093);
    cycle();
    check("f1_instr", {32'd0, u_bus.id_instr}, 64'h00A0_0113);
    check("f1_pc", u_bus.pc_addr, 64'd8);

    // Two stall cycles at PC 8, then resume
    set_ctl(1, 0, 0, 0);
    cycle(); cycle();
    check("stall_pc", u_bus.pc_addr, 64'd8);
    set_ctl(0, 0, 0, 0);
    cycle();
    check("resume_pc", u_bus.pc_addr, 64'd12);

    // Redirect beats flush and stall
    set_ctl(1, 1, 1, 64'h100);
    cycle();
    check("redir_pc", u_bus.pc_addr, 64'h100);
    check("redir_valid", {63'd0, u_bus.id_valid}, 64'd0);
    set_ctl(0, 0, 0, 0);
    cycle();
    check("redir_idpc", u_bus.id_pc, 64'h100);

    // Flush alone, with stall
    set_ctl(1, 1, 0, 0);
    cycle();
    set_ctl(0, 0, 0, 0);

    // Imem fault at 0x40000: reported once, then frozen until redirect
    set_ctl(0, 0, 1, 64'h40000);
    cycle();
    set_ctl(0, 0, 0, 0);
    drv_exc = 1'b1; drv_code = 4'd1;
    cycle();
    check("fault_code", {60'd0, u_bus.id_exc_code}, 64'd1);
    check("fault_val", u_bus.id_exc_val, 64'h40000);
    cycle(); cycle(); cycle();
    check("fault_frozen", u_bus.pc_addr, 64'h40000);
    check("fault_bubble", {63'd0, u_bus.id_exc_en}, 64'd0);
    drv_exc = 1'b0; drv_code = 4'd0;
    set_ctl(0, 0, 1, 64'h80);
    cycle();
    set_ctl(0, 0, 0, 0);
    cycle();
    check("fault_resume", u_bus.id_pc, 64'h80);

    // Misaligned redirect
    set_ctl(0, 0, 1, 64'h102);
    cycle();
    check("mis_val", u_bus.id_exc_val, 64'h102);
    check("mis_pc", u_bus.pc_addr, 64'h84);
    set_ctl(1, 0, 0, 0);
    cycle();

    // Reset while in FAULT and stalled
    rst = 1'b0;
    cycle();
    check("rst_fault", {63'd0, dbg_fault}, 64'd0);
    rst = 1'b1;
    set_ctl(0, 0, 0, 0);

    // PC wrap
    set_ctl(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    set_ctl(0, 0, 0, 0);
    cycle();
    check("wrap_pc", u_bus.pc_addr, 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      u_bus.stall = ($urandom_range(0, 3) == 0);
      u_bus.flush = ($urandom_range(0, 9) == 0);
      u_bus.redirect_en = ($urandom_range(0, 11) == 0);
      u_bus.redirect_pc = {50'd0, 12'($urandom_range(0, 4095)), 2'b00};
      if ($urandom_range(0, 3) == 0) u_bus.redirect_pc[1:0] = 2'($urandom_range(1, 3));
      drv_exc = ($urandom_range(0, 14) == 0);
      drv_code = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
